// File: rtl/alu_wb_queue_if.sv
// Bundle of the ALU-result, flag, register-file drain and forwarding signals
// between the ALU side (master) and the write-back queue (slave).
interface alu_wb_queue_if #(
    parameter int WIDTH  = 32,
    parameter int RWIDTH = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_res;
    logic [7:0]        in_fo;
    logic              in_wb_en;
    logic              in_flag_en;
    logic [RWIDTH-1:0] in_rd;
    logic [7:0]        flags;
    logic              flags_we;
    logic [7:0]        flags_wd;
    logic              rf_valid;
    logic              rf_ready;
    logic [RWIDTH-1:0] rf_addr;
    logic [WIDTH-1:0]  rf_data;
    logic [RWIDTH-1:0] fwd_addr;
    logic              fwd_hit;
    logic [WIDTH-1:0]  fwd_data;
    logic [1:0]        count;

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; ready never depends combinationally on valid.
    modport master (
        output in_valid, in_res, in_fo, in_wb_en, in_flag_en, in_rd,
        output flags_we, flags_wd, rf_ready, fwd_addr,
        input  in_ready, flags, rf_valid, rf_addr, rf_data, fwd_hit, fwd_data, count
    );

    modport slave (
        input  in_valid, in_res, in_fo, in_wb_en, in_flag_en, in_rd,
        input  flags_we, flags_wd, rf_ready, fwd_addr,
        output in_ready, flags, rf_valid, rf_addr, rf_data, fwd_hit, fwd_data, count
    );
endinterface

// File: rtl/alu_wb_queue.sv
// ALU write-back stage: owns the flag register, queues register write-backs in
// a 2-entry FIFO drained to the register file, and forwards pending results.
module alu_wb_queue #(
    parameter int WIDTH  = 32,
    parameter int RWIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_wb_queue_if.slave bus
);
    logic [WIDTH-1:0]  data_q [2];
    logic [RWIDTH-1:0] rd_q   [2];
    logic              rptr;
    logic              wptr;
    logic [1:0]        cnt;
    logic              ready_q;
    logic [7:0]        flags_q;

    logic              acc;
    logic              push;
    logic              pop;
    logic [1:0]        count_next;
    logic              young_idx;

    assign acc        = bus.in_valid & ready_q;
    assign push       = acc & bus.in_wb_en;
    assign pop        = (cnt != 2'd0) & bus.rf_ready;
    assign count_next = cnt + {1'b0, push} - {1'b0, pop};
    assign young_idx  = wptr ^ 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 2'd0;
            rptr    <= 1'b0;
            wptr    <= 1'b0;
            ready_q <= 1'b1;
            flags_q <= 8'h00;
        end else begin
            cnt     <= count_next;
            rptr    <= rptr ^ pop;
            wptr    <= wptr ^ push;
            ready_q <= (count_next < 2'd2);
            // An explicit flag restore overrides the ALU's flags in the same cycle.
            if (bus.flags_we)
                flags_q <= bus.flags_wd;
            else if (acc && bus.in_flag_en)
                flags_q <= bus.in_fo;
        end
    end

    // Payload storage needs no reset: every read of it is gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wptr] <= bus.in_res;
            rd_q[wptr]   <= bus.in_rd;
        end
    end

    assign bus.count    = cnt;
    assign bus.in_ready = ready_q;
    assign bus.flags    = flags_q;
    assign bus.rf_valid = (cnt != 2'd0);
    assign bus.rf_addr  = (cnt != 2'd0) ? rd_q[rptr]   : '0;
    assign bus.rf_data  = (cnt != 2'd0) ? data_q[rptr] : '0;

    // Youngest entry sits just behind the write pointer; the older one (when
    // two are pending) sits at the write pointer itself.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        if ((cnt != 2'd0) && (rd_q[young_idx] == bus.fwd_addr)) begin
            bus.fwd_hit  = 1'b1;
            bus.fwd_data = data_q[young_idx];
        end else if ((cnt == 2'd2) && (rd_q[wptr] == bus.fwd_addr)) begin
            bus.fwd_hit  = 1'b1;
            bus.fwd_data = data_q[wptr];
        end
    end
endmodule

// File: tb/tb_alu_wb_queue.sv
// Self-checking bench for alu_wb_queue: directed scenarios then random traffic,
// checked against a queue-based reference model and a drain scoreboard.
module tb_alu_wb_queue;
    localparam int WIDTH  = 32;
    localparam int RWIDTH = 4;

    logic clk;
    logic reset;

    alu_wb_queue_if #(.WIDTH(WIDTH), .RWIDTH(RWIDTH)) bus ();

    alu_wb_queue #(.WIDTH(WIDTH), .RWIDTH(RWIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending entries oldest-first, plus the flag register.
    logic [RWIDTH+WIDTH-1:0] model_q[$];
    logic [RWIDTH+WIDTH-1:0] exp_q[$];
    logic [7:0]              model_flags;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [WIDTH:0] model_fwd(input logic [RWIDTH-1:0] addr);
        // Returns {hit, data} for the youngest pending entry targeting addr.
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i][RWIDTH+WIDTH-1:WIDTH] == addr)
                return {1'b1, model_q[i][WIDTH-1:0]};
        end
        return '0;
    endfunction

    task automatic check_outputs();
        logic [WIDTH:0] f;
        int n;
        n = model_q.size();
        f = model_fwd(bus.fwd_addr);
        check("count",    32'(bus.count),    32'(n));
        check("in_ready", 32'(bus.in_ready), 32'(n < 2));
        check("rf_valid", 32'(bus.rf_valid), 32'(n != 0));
        check("flags",    32'(bus.flags),    32'(model_flags));
        check("fwd_hit",  32'(bus.fwd_hit),  32'(f[WIDTH]));
        check("fwd_data", bus.fwd_data,      f[WIDTH-1:0]);
        if (n != 0) begin
            check("rf_addr", 32'(bus.rf_addr), 32'(model_q[0][RWIDTH+WIDTH-1:WIDTH]));
            check("rf_data", bus.rf_data,      model_q[0][WIDTH-1:0]);
        end
    endtask

    // Driver: apply one cycle of inputs just after a rising edge, check at the
    // falling edge, then advance the model by what the next edge will do.
    task automatic cycle(input logic v, input logic [RWIDTH-1:0] rd, input logic [WIDTH-1:0] res,
                         input logic [7:0] fo, input logic wb, input logic fe,
                         input logic fwe, input logic [7:0] fwd_wd, input logic rdy,
                         input logic [RWIDTH-1:0] faddr);
        logic acc;
        bus.in_valid   = v;
        bus.in_rd      = rd;
        bus.in_res     = res;
        bus.in_fo      = fo;
        bus.in_wb_en   = wb;
        bus.in_flag_en = fe;
        bus.flags_we   = fwe;
        bus.flags_wd   = fwd_wd;
        bus.rf_ready   = rdy;
        bus.fwd_addr   = faddr;
        @(negedge clk);
        check_outputs();
        acc = v && (model_q.size() < 2);
        if (rdy && model_q.size() != 0) void'(model_q.pop_front());
        if (acc && wb) begin
            model_q.push_back({rd, res});
            exp_q.push_back({rd, res});
        end
        if (fwe) model_flags = fwd_wd;
        else if (acc && fe) model_flags = fo;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input logic [RWIDTH-1:0] faddr);
        cycle(1'b0, '0, '0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, rdy, faddr);
    endtask

    // Scoreboard monitor: every accepted drain must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && bus.rf_valid && bus.rf_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL drain_unexpected: got addr %0h data %0h expected none", bus.rf_addr, bus.rf_data);
            end else begin
                logic [RWIDTH+WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("drain", {bus.rf_addr, bus.rf_data}, e[WIDTH-1:0]);
                check("drain_addr", 32'(bus.rf_addr), 32'(e[RWIDTH+WIDTH-1:WIDTH]));
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_res = '0; bus.in_fo = '0;
        bus.in_wb_en = 1'b0; bus.in_flag_en = 1'b0; bus.flags_we = 1'b0;
        bus.flags_wd = '0; bus.rf_ready = 1'b0; bus.fwd_addr = '0;
        model_flags = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // Single push with immediate drain
        cycle(1, 4'd3, 32'h1234_5678, 8'h00, 1, 0, 0, 8'h00, 1, 4'd3);
        idle(1, 4'd3);
        idle(1, 4'd3);

        // Fill to two with stalled port, forward youngest, ignored third push
        cycle(1, 4'd1, 32'hA, 8'h00, 1, 0, 0, 8'h00, 0, 4'd1);
        cycle(1, 4'd1, 32'hB, 8'h00, 1, 0, 0, 8'h00, 0, 4'd1);
        cycle(1, 4'd2, 32'hC, 8'h00, 1, 0, 0, 8'h00, 0, 4'd1);
        idle(0, 4'd1);
        idle(1, 4'd1);
        idle(1, 4'd1);
        idle(1, 4'd1);

        // Flags-only instruction, then restore colliding with an ALU flag write
        cycle(1, 4'd5, 32'hDEAD, 8'h05, 0, 1, 0, 8'h00, 1, 4'd5);
        idle(1, 4'd5);
        cycle(1, 4'd6, 32'hBEEF, 8'h01, 0, 1, 1, 8'h80, 1, 4'd6);
        idle(1, 4'd6);

        // Steady push+pop at count=1, exercising pointer wrap
        cycle(1, 4'd7, 32'h100, 8'h00, 1, 0, 0, 8'h00, 0, 4'd7);
        for (int i = 0; i < 4; i++)
            cycle(1, 4'(8 + i), 32'h200 + 32'(i), 8'h00, 1, 0, 0, 8'h00, 1, 4'(8 + i));
        idle(1, 4'd11);
        idle(1, 4'd11);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), $urandom(),
                  8'($urandom()), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) == 0), 8'($urandom()),
                  1'($urandom_range(0, 9) < 7), 4'($urandom_range(0, 3)));
        end

        // Asynchronous reset while full and presenting
        cycle(1, 4'd4, 32'h44, 8'h3C, 1, 1, 0, 8'h00, 0, 4'd4);
        cycle(1, 4'd4, 32'h55, 8'h00, 1, 0, 0, 8'h00, 0, 4'd4);
        idle(0, 4'd4);
        #1 reset = 1'b1;
        #1;
        check("rst_rf_valid", 32'(bus.rf_valid), 32'h0);
        check("rst_count",    32'(bus.count),    32'h0);
        check("rst_flags",    32'(bus.flags),    32'h0);
        check("rst_fwd_hit",  32'(bus.fwd_hit),  32'h0);
        check("rst_fwd_data", bus.fwd_data,      32'h0);
        check("rst_rf_data",  bus.rf_data,       32'h0);
        model_q.delete();
        exp_q.delete();
        model_flags = 8'h00;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'h1);
        cycle(1, 4'd9, 32'h99, 8'h00, 1, 0, 0, 8'h00, 1, 4'd9);
        idle(1, 4'd9);
        idle(1, 4'd9);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_wb_queue.md
Name: alu_wb_queue

Overview:
- Downstream neighbour of the ALU: accepts per-instruction results (res, fo, wb_en, flag_en) and owns the architectural 8-bit flag register that drives the ALU flag input.
- Queues register write-backs in a 2-entry FIFO and drains them into the register file write port under a valid/ready handshake. The port is shared with memory loads, so it can stall.
- Provides youngest-first forwarding of pending write-back data to operand fetch.

Parameters:
- WIDTH, 32, data path width.
- RWIDTH, 4, register index width (16 registers).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  stage can accept; registered, equals (count<2).
- in_res  in  WIDTH  ALU result.
- in_fo  in  8  ALU output flags.
- in_wb_en  in  1  result must be written to in_rd.
- in_flag_en  in  1  in_fo must be written to flag register.
- in_rd  in  RWIDTH  destination register index.
- flags  out  8  architectural flag register; feeds ALU fi.
- flags_we  in  1  external flag write (flag restore).
- flags_wd  in  8  external flag write data.
- rf_valid  out  1  head entry presented to register file.
- rf_ready  in  1  register file accepts this cycle.
- rf_addr  out  RWIDTH  head entry destination.
- rf_data  out  WIDTH  head entry data.
- fwd_addr  in  RWIDTH  operand register index to look up.
- fwd_hit  out  1  a pending entry targets fwd_addr.
- fwd_data  out  WIDTH  data of the youngest matching pending entry.
- count  out  2  pending entries (0..2).

Behaviour:
- Accept condition: acc = in_valid & in_ready.
  - in_ready depends only on the registered count; there is no combinational path from rf_ready or in_valid.
- Enqueue: on acc & in_wb_en, push {in_rd, in_res} at the tail.
  - acc & !in_wb_en pushes nothing; the instruction is consumed for flags only.
- Flags: the flag register is updated at the clock edge of acc & in_flag_en, taking in_fo.
  - The new value is visible on flags the next cycle (1-cycle latency), so a back-to-back ALU op sees the updated flags.
  - flags_we in the same cycle as acc & in_flag_en: flags_we wins, and in_fo is dropped.
  - The flag update never depends on FIFO space beyond the acc condition.
- Drain: rf_valid = (count!=0); rf_addr and rf_data come from the head entry.
  - On rf_valid & rf_ready the head pops.
  - rf_addr and rf_data hold stable while rf_valid & !rf_ready.
- Simultaneous push and pop: count is unchanged.
  - With count=1 the new entry becomes head next cycle.
  - With count=2 no push is possible because in_ready=0.
- FIFO storage: circular, 2 slots, with 1-bit read and write pointers that wrap 1->0. A pop at count=0 is impossible (rf_valid=0).
- count next = count + push - pop. in_ready next = (count_next<2).
- Forwarding (combinational from stored state only; no bypass of in_res):
  - The youngest valid entry whose rd==fwd_addr supplies fwd_data and asserts fwd_hit.
  - If no entry matches: fwd_hit=0, fwd_data=0.
  - An entry popping this cycle still forwards this cycle.
- Reset (asynchronous, any time including mid-drain):
  - count=0, pointers=0, flags=8'h00, in_ready=1 (ready asserted from reset release), rf_valid=0.
  - rf_addr=0, rf_data=0, fwd_hit=0, fwd_data=0.
  - Storage contents are don't-care but must not leak: outputs are gated by valid.
- No data width conversion: in_res is stored and output unmodified at WIDTH bits.

Test Plan:
- Reset, then push in_rd=3, in_res=32'h1234_5678, wb_en=1, rf_ready=1 -> next cycle rf_valid=1, rf_addr=3, rf_data=32'h12345678; popped at that edge; count back to 0.
- rf_ready=0; push rd=1 data=32'hA, then rd=1 data=32'hB -> count=2, in_ready=0. fwd_addr=1 gives fwd_hit=1, fwd_data=32'hB. Third push attempt is ignored. After rf_ready=1, two drains occur in order A then B.
- Push flags-only: wb_en=0, flag_en=1, in_fo=8'h05 -> flags=8'h05 next cycle, count stays 0.
- Same cycle: acc with flag_en=1, in_fo=8'h01, plus flags_we=1, flags_wd=8'h80 -> flags=8'h80.
- count=1, rf_ready=1, push in the same cycle -> count stays 1; new entry at head with correct rf_addr/rf_data; pointers wrap correctly over 4 consecutive iterations.
- Assert reset while count=2 and rf_valid=1 -> outputs immediately (asynchronously) rf_valid=0, count=0, flags=0, fwd_hit=0; after release, in_ready=1.
